mips_mc_ctrl: RTL and testbench

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/mips_mc_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS control FSM with memory-wait timeout and sticky error
// Optional ORI support is built in when MIPS_MC_CTRL_ORI_EN is defined.
module mips_mc_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [2:0] alu_cont,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        IWB     = 4'd10,
        JEX     = 4'd11,
        ORIEX   = 4'd12
    } state_t;

    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    state_t          cur_state;
    state_t          nxt_state;
    logic [CW-1:0]   wait_cnt;
    logic            err_q;
    logic            err_set;
    logic            pc_write;
    logic            branch;
    logic            waiting;
    logic            timeout;
`ifdef MIPS_MC_CTRL_ORI_EN
    logic            zext_c;
`endif

    assign waiting = ((cur_state == FETCH) || (cur_state == MEMRD) || (cur_state == MEMWR)) && !mem_ready;
    // The TIMEOUT_CYCLES-th idle cycle is the last one; the FSM leaves at its closing edge.
    assign timeout = waiting && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            err_q     <= err_q | err_set;
            // Any state change (or re-entry of FETCH after a timeout) restarts the wait count.
            if ((nxt_state != cur_state) || timeout) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        err_set    = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_cont   = 3'b000;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
`ifdef MIPS_MC_CTRL_ORI_EN
        zext_c     = 1'b0;
`endif
        case (cur_state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_cont  = 3'b010;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nxt_state = DECODE;
                end else if (timeout) begin
                    err_set   = 1'b1;
                    nxt_state = FETCH;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_cont  = 3'b010;
                case (op)
                    6'b100011, 6'b101011: nxt_state = MEMADR;
                    6'b000000:            nxt_state = RTYPEEX;
                    6'b000100:            nxt_state = BEQEX;
                    6'b001000:            nxt_state = ADDIEX;
                    6'b000010:            nxt_state = JEX;
`ifdef MIPS_MC_CTRL_ORI_EN
                    6'b001101:            nxt_state = ORIEX;
`endif
                    default: begin
                        err_set   = 1'b1;
                        nxt_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_cont  = 3'b010;
                nxt_state = (op == 6'b100011) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    nxt_state = MEMWB;
                end else if (timeout) begin
                    err_set   = 1'b1;
                    nxt_state = FETCH;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt_state  = FETCH;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                // An abandoned store must not strobe on its final cycle.
                mem_write = !timeout;
                if (mem_ready) begin
                    nxt_state = FETCH;
                end else if (timeout) begin
                    err_set   = 1'b1;
                    nxt_state = FETCH;
                end
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                nxt_state = RTYPEWB;
                case (funct)
                    6'b100000: alu_cont = 3'b010;
                    6'b100010: alu_cont = 3'b110;
                    6'b100100: alu_cont = 3'b000;
                    6'b100101: alu_cont = 3'b001;
                    6'b101010: alu_cont = 3'b111;
                    default: begin
                        err_set   = 1'b1;
                        nxt_state = FETCH;
                    end
                endcase
            end
            RTYPEWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                nxt_state = FETCH;
            end
            BEQEX: begin
                alu_src_a = 1'b1;
                alu_cont  = 3'b110;
                pc_src    = 2'b01;
                branch    = 1'b1;
                nxt_state = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_cont  = 3'b010;
                nxt_state = IWB;
            end
            IWB: begin
                reg_write = 1'b1;
                nxt_state = FETCH;
            end
            JEX: begin
                pc_src    = 2'b10;
                pc_write  = 1'b1;
                nxt_state = FETCH;
            end
`ifdef MIPS_MC_CTRL_ORI_EN
            ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                zext_c    = 1'b1;
                alu_cont  = 3'b001;
                nxt_state = IWB;
            end
`endif
            default: nxt_state = FETCH;
        endcase
    end

`ifdef MIPS_MC_CTRL_ORI_EN
    assign imm_zext = zext_c;
`else
    assign imm_zext = 1'b0;
`endif

    assign pc_en = pc_write | (branch & zero);
    assign err   = err_q;
    assign state = cur_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - randomized instruction-level check of mips_mc_ctrl against a sequence model
module tb_mips_mc_ctrl;

    localparam int T = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, i_or_d, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [2:0] alu_cont;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       err;
    logic [3:0] state;

    mips_mc_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_cont(alu_cont), .pc_src(pc_src),
        .pc_en(pc_en), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    logic [16:0] dut_vec;
    assign dut_vec = {mem_req, mem_write, i_or_d, ir_write, reg_write, reg_dst, mem_to_reg,
                      alu_src_a, alu_src_b, imm_zext, alu_cont, pc_src, pc_en};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int   st;
        logic rdy;
        logic ev;
    } step_t;

    step_t plan[$];
    logic  model_err;

    function automatic logic r_ok(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    // Expected control word per state, straight from the state output table.
    function automatic logic [16:0] exp_ctrl(input int s, input logic [5:0] f, input logic rdy,
                                             input logic z, input logic ev);
        logic mreq, mw, iod, irw, rw, rd, m2r, sa, zx, pce;
        logic [1:0] sb, pcs;
        logic [2:0] alu;
        {mreq, mw, iod, irw, rw, rd, m2r, sa, zx, pce} = '0;
        sb = 2'b00; pcs = 2'b00; alu = 3'b000;
        case (s)
            0:  begin mreq = 1; sb = 2'b01; alu = 3'b010; irw = rdy; pce = rdy; end
            1:  begin sb = 2'b11; alu = 3'b010; end
            2:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
            3:  begin mreq = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mreq = 1; iod = 1; mw = !ev; end
            6:  begin sa = 1; alu = r_alu(f); end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; alu = 3'b110; pcs = 2'b01; pce = z; end
            9:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
            10: begin rw = 1; end
            11: begin pcs = 2'b10; pce = 1; end
            12: begin sa = 1; sb = 2'b10; zx = 1; alu = 3'b001; end
            default: ;
        endcase
        return {mreq, mw, iod, irw, rw, rd, m2r, sa, sb, zx, alu, pcs, pce};
    endfunction

    task automatic add_wait(input int s, input int d, output bit aborted);
        aborted = (d >= T);
        if (aborted) begin
            for (int i = 0; i < T; i++) plan.push_back('{s, 1'b0, (i == T - 1)});
        end else begin
            for (int i = 0; i < d; i++) plan.push_back('{s, 1'b0, 1'b0});
            plan.push_back('{s, 1'b1, 1'b0});
        end
    endtask

    task automatic add_fixed(input int s, input bit ev);
        plan.push_back('{s, 1'($urandom), ev});
    endtask

    // Expected state sequence of one instruction, from fetch to its return to FETCH.
    task automatic build(input logic [5:0] o, input logic [5:0] f, input int df, input int dm);
        bit ab;
        plan.delete();
        add_wait(0, df, ab);
        if (ab) return;
        case (o)
            6'b100011: begin add_fixed(1, 0); add_fixed(2, 0); add_wait(3, dm, ab); if (!ab) add_fixed(4, 0); end
            6'b101011: begin add_fixed(1, 0); add_fixed(2, 0); add_wait(5, dm, ab); end
            6'b000000: begin
                add_fixed(1, 0);
                if (r_ok(f)) begin add_fixed(6, 0); add_fixed(7, 0); end
                else add_fixed(6, 1);
            end
            6'b000100: begin add_fixed(1, 0); add_fixed(8, 0); end
            6'b001000: begin add_fixed(1, 0); add_fixed(9, 0); add_fixed(10, 0); end
            6'b000010: begin add_fixed(1, 0); add_fixed(11, 0); end
`ifdef MIPS_MC_CTRL_ORI_EN
            6'b001101: begin add_fixed(1, 0); add_fixed(12, 0); add_fixed(10, 0); end
`endif
            default:   add_fixed(1, 1);
        endcase
    endtask

    // Entered and left at a falling edge; inputs change and outputs are sampled there.
    task automatic run_plan(input int n);
        for (int i = 0; i < plan.size() && i < n; i++) begin
            mem_ready = plan[i].rdy;
            zero      = 1'($urandom);
            #1;
            check("state", 32'(state), 32'(plan[i].st));
            check("err", 32'(err), 32'(model_err));
            check("ctrl", 32'(dut_vec), 32'(exp_ctrl(plan[i].st, funct, plan[i].rdy, zero, plan[i].ev)));
            if (plan[i].ev) model_err = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic instr(input logic [5:0] o, input logic [5:0] f, input int df, input int dm);
        op    = o;
        funct = f;
        build(o, f, df, dm);
        run_plan(plan.size());
    endtask

    logic [5:0] ops [9];
    logic [5:0] rfs [6];

    initial begin
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                6'b000010, 6'b001101, 6'b111111, 6'b000000};
        rfs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0; model_err = 1'b0;
        @(negedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b1;

        instr(6'b100011, 6'b000000, 0, 0);
        instr(6'b000000, 6'b101010, 0, 0);
        instr(6'b000100, 6'b000000, 1, 0);
        instr(6'b000100, 6'b000000, 0, 0);
        instr(6'b001000, 6'b000000, 2, 0);
        instr(6'b101011, 6'b000000, 0, 3);
        instr(6'b000000, 6'b111000, 0, 0);
        instr(6'b001101, 6'b000000, 0, 0);
        instr(6'b000010, 6'b000000, 0, 0);
        instr(6'b100011, 6'b000000, T, 0);
        instr(6'b111111, 6'b000000, 0, 0);
        instr(6'b100011, 6'b000000, 0, T);
        instr(6'b101011, 6'b000000, 0, T);
        instr(6'b100011, 6'b000000, 1, 1);

        // Store stalled three cycles in MEMWR, then reset pulsed mid-wait.
        op = 6'b101011; funct = '0;
        build(op, funct, 0, 3);
        run_plan(6);
        mem_ready = 1'b0;
        #1;
        check("memwr_state", 32'(state), 32'd5);
        check("memwr_strobe", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_mem_write", 32'(mem_write), 32'd0);
        check("rst_mid_err", 32'(err), 32'd0);
        model_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 200; k++) begin
            logic [5:0] o, f;
            int df, dm;
            o  = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            f  = ($urandom_range(0, 5) == 5) ? 6'($urandom) : rfs[$urandom_range(0, 5)];
            df = ($urandom_range(0, 24) == 0) ? T : int'($urandom_range(0, 3));
            dm = ($urandom_range(0, 15) == 0) ? T : int'($urandom_range(0, 3));
            instr(o, f, df, dm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
